// File: rtl/conv_window_gen.sv
// 3x3 sliding-window generator over a raster pixel stream using two line buffers.
// Latency: window registered 1 cycle after the pixel that completes it is accepted.
// Backpressure: none; every pixel_valid_in pixel is consumed (or dropped in ERR/clear).
module conv_window_gen #(
    parameter int DATA_WIDTH = 8,
    parameter int MAC_IN_NUM = 9,
    parameter int MAX_WIDTH  = 256,
    parameter int DIM_WIDTH  = 9
) (
    input  logic                             clk,
    input  logic                             rstn,
    input  logic [DATA_WIDTH-1:0]            pixel_in,
    input  logic                             pixel_valid_in,
    input  logic [DIM_WIDTH-1:0]             img_width_in,
    input  logic [DIM_WIDTH-1:0]             img_height_in,
    input  logic                             clear_in,
    output logic [MAC_IN_NUM*DATA_WIDTH-1:0] MAC_data_out,
    output logic                             MAC_data_valid_out,
    output logic                             frame_done_out,
    output logic                             busy_out,
    output logic                             cfg_err_out
);

    localparam int AW = (MAX_WIDTH > 1) ? $clog2(MAX_WIDTH) : 1;
    localparam logic [DIM_WIDTH-1:0] DIM_ONE   = DIM_WIDTH'(1);
    localparam logic [DIM_WIDTH-1:0] DIM_TWO   = DIM_WIDTH'(2);
    localparam logic [DIM_WIDTH-1:0] DIM_THREE = DIM_WIDTH'(3);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        ERR  = 2'd2
    } state_t;

    state_t                          state_q;
    logic [DIM_WIDTH-1:0]            w_q;
    logic [DIM_WIDTH-1:0]            h_q;
    logic [DIM_WIDTH-1:0]            row_q;
    logic [DIM_WIDTH-1:0]            col_q;
    logic                            vld_q;
    logic                            done_q;
    logic                            busy_q;
    logic                            err_q;
    logic [MAC_IN_NUM*DATA_WIDTH-1:0] mac_q;

    // lb1 holds the previous row, lb2 the row before that, indexed by column.
    logic [DATA_WIDTH-1:0]           lb1_q [MAX_WIDTH];
    logic [DATA_WIDTH-1:0]           lb2_q [MAX_WIDTH];
    // Two most recent window columns; element 0 is the top (oldest) row.
    logic [2:0][DATA_WIDTH-1:0]      col1_q;
    logic [2:0][DATA_WIDTH-1:0]      col2_q;

    logic [2:0][DATA_WIDTH-1:0]      new_col_d;
    logic [MAC_IN_NUM*DATA_WIDTH-1:0] window_d;
    logic [AW-1:0]                   addr;
    logic                            cfg_ok;
    logic                            accept;
    logic                            emit;
    logic                            last_col;
    logic                            last_row;

    assign addr     = col_q[AW-1:0];
    assign cfg_ok   = (img_width_in >= DIM_THREE)
                   && (32'(img_width_in) <= 32'(MAX_WIDTH))
                   && (img_height_in >= DIM_THREE);
    // A pixel enters the datapath only when it becomes part of a live frame.
    assign accept   = rstn && pixel_valid_in && !clear_in
                   && ((state_q == RUN) || ((state_q == IDLE) && cfg_ok));
    assign last_col = (col_q == (w_q - DIM_ONE));
    assign last_row = (row_q == (h_q - DIM_ONE));
    // Windows only form once two full rows and two columns of the current row exist,
    // so stale line-buffer contents from older frames are never selected.
    assign emit     = accept && (state_q == RUN) && (row_q >= DIM_TWO) && (col_q >= DIM_TWO);

    // Assemble the incoming column and the candidate 3x3 window.
    always_comb begin
        new_col_d    = '0;
        window_d     = '0;
        new_col_d[0] = lb2_q[addr];
        new_col_d[1] = lb1_q[addr];
        new_col_d[2] = pixel_in;
        for (int r = 0; r < 3; r++) begin
            window_d[(r*3+0)*DATA_WIDTH +: DATA_WIDTH] = col2_q[r];
            window_d[(r*3+1)*DATA_WIDTH +: DATA_WIDTH] = col1_q[r];
            window_d[(r*3+2)*DATA_WIDTH +: DATA_WIDTH] = new_col_d[r];
        end
    end

    // Line buffers and column shift registers advance only on accepted pixels.
    always_ff @(posedge clk) begin
        if (accept) begin
            lb2_q[addr] <= lb1_q[addr];
            lb1_q[addr] <= pixel_in;
            col2_q      <= col1_q;
            col1_q      <= new_col_d;
        end
    end

    // Frame-control FSM with raster counters and registered outputs.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= IDLE;
            w_q     <= '0;
            h_q     <= '0;
            row_q   <= '0;
            col_q   <= '0;
            vld_q   <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
            mac_q   <= '0;
        end else if (clear_in) begin
            state_q <= IDLE;
            row_q   <= '0;
            col_q   <= '0;
            vld_q   <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            vld_q  <= 1'b0;
            done_q <= 1'b0;
            if (emit) begin
                vld_q <= 1'b1;
                mac_q <= window_d;
            end
            case (state_q)
                IDLE: begin
                    if (pixel_valid_in) begin
                        w_q <= img_width_in;
                        h_q <= img_height_in;
                        if (cfg_ok) begin
                            state_q <= RUN;
                            busy_q  <= 1'b1;
                            row_q   <= '0;
                            col_q   <= DIM_ONE;
                        end else begin
                            state_q <= ERR;
                            err_q   <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (pixel_valid_in) begin
                        if (last_col) begin
                            col_q <= '0;
                            if (last_row) begin
                                row_q   <= '0;
                                state_q <= IDLE;
                                busy_q  <= 1'b0;
                                done_q  <= 1'b1;
                            end else begin
                                row_q <= row_q + DIM_ONE;
                            end
                        end else begin
                            col_q <= col_q + DIM_ONE;
                        end
                    end
                end
                ERR: begin
                    state_q <= ERR;
                    err_q   <= 1'b1;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    err_q   <= 1'b0;
                end
            endcase
        end
    end

    assign MAC_data_out       = mac_q;
    assign MAC_data_valid_out = vld_q;
    assign frame_done_out     = done_q;
    assign busy_out           = busy_q;
    assign cfg_err_out        = err_q;

endmodule

// File: doc/conv_window_gen.md
CONV_WINDOW_GEN -- requirements
Module: conv_window_gen

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 8, meaning pixel width in bits.
REQ-002 The block SHALL have parameter MAC_IN_NUM, default 9, meaning window size (3x3); only 9 is supported.
REQ-003 The block SHALL have parameter MAX_WIDTH, default 256, meaning maximum image width in pixels (line-buffer depth).
REQ-004 The block SHALL have parameter DIM_WIDTH, default 9, meaning width of image-dimension inputs.
REQ-005 The block SHALL have port clk, input, 1 bit, meaning the single clock; all logic is rising-edge.
REQ-006 The block SHALL have port rstn, input, 1 bit, meaning synchronous active-low reset.
REQ-007 The block SHALL have port pixel_in, input, DATA_WIDTH bits, meaning raster-order pixel (row-major, left to right).
REQ-008 The block SHALL have port pixel_valid_in, input, 1 bit, meaning pixel_in is accepted this cycle; there is no backpressure.
REQ-009 The block SHALL have port img_width_in, input, DIM_WIDTH bits, meaning image width W; sampled only on a frame's first pixel.
REQ-010 The block SHALL have port img_height_in, input, DIM_WIDTH bits, meaning image height H; sampled with img_width_in.
REQ-011 The block SHALL have port clear_in, input, 1 bit, meaning synchronous frame abort.
REQ-012 The block SHALL have port MAC_data_out, output, MAC_IN_NUM*DATA_WIDTH bits, meaning 3x3 window; slice k = [k*DATA_WIDTH +: DATA_WIDTH], k = r*3+c, r=0 top (oldest) row, c=0 leftmost column.
REQ-013 The block SHALL have port MAC_data_valid_out, output, 1 bit, meaning MAC_data_out holds a valid window this cycle.
REQ-014 The block SHALL have port frame_done_out, output, 1 bit, meaning one-cycle pulse coincident with a frame's last window.
REQ-015 The block SHALL have port busy_out, output, 1 bit, meaning the state is RUN.
REQ-016 The block SHALL have port cfg_err_out, output, 1 bit, meaning the state is ERR.

Function
REQ-017 The block SHALL implement states IDLE, RUN and ERR.
REQ-018 In IDLE, an accepted pixel SHALL latch W and H; if 3<=W<=MAX_WIDTH and 3<=H then the pixel is stored as (row 0, col 0) and the state becomes RUN, else the pixel is dropped and the state becomes ERR.
REQ-019 In RUN, each accepted pixel SHALL advance col; col wraps to 0 at W-1 and row increments on wrap.
REQ-020 Idle gaps (pixel_valid_in=0) SHALL NOT advance counters, alter stored data, or produce output.
REQ-021 Accepting the pixel at (row>=2, col>=2) SHALL produce exactly one window: rows row-2..row, cols col-2..col, with MAC_data_valid_out=1 on the next cycle (latency 1).
REQ-022 Windows SHALL NOT span a row wrap; W-2 windows per row, (W-2)*(H-2) per frame.
REQ-023 MAC_data_out SHALL hold its last value when MAC_data_valid_out=0.
REQ-024 Accepting pixel (H-1, W-1) SHALL assert frame_done_out together with the final window and return the state to IDLE; the next pixel starts a new frame with resampled W/H.
REQ-025 A pixel arriving the cycle after the last pixel SHALL be accepted as (0,0) of the next frame with no lost cycle.
REQ-026 ERR SHALL ignore pixels and persist until clear_in or reset.
REQ-027 clear_in=1 SHALL force IDLE, zero row/col and suppress the output for the pixel of that cycle; next-cycle MAC_data_valid_out=0 and frame_done_out=0.
REQ-028 If clear_in and pixel_valid_in are simultaneous, clear SHALL win and the pixel SHALL be dropped.
REQ-029 A window already registered before clear_in SHALL still present on its scheduled cycle.
REQ-030 Line-buffer contents SHALL NOT need clearing; no window may include data from a previous frame.

Reset
REQ-031 While rstn=0 at a clock edge, the state SHALL become IDLE, counters 0, MAC_data_out 0, and MAC_data_valid_out, frame_done_out, busy_out and cfg_err_out 0.
REQ-032 Reset SHALL take priority over clear_in and pixel_valid_in.
REQ-033 Mid-frame reset SHALL discard the partial frame.

Verification
REQ-034 The bench SHALL cover: W=4,H=4, pixels 0..15 back-to-back -> 4 windows; first {0,1,2,4,5,6,8,9,10} one cycle after pixel 10; last {5,6,7,9,10,11,13,14,15} with frame_done_out=1.
REQ-035 The bench SHALL cover: the same frame with random 0-3 cycle gaps -> identical 4 windows in order, and valid only one cycle after completing pixels.
REQ-036 The bench SHALL cover: W=2 first pixel -> cfg_err_out=1, no windows; then clear_in -> IDLE; then a W=3,H=3 frame of 1..9 -> one window {1..9} plus frame_done_out.
REQ-037 The bench SHALL cover: clear_in coincident with pixel 10 of a 4x4 frame -> no window next cycle; the next frame (0..15) yields the REQ-034 results.
REQ-038 The bench SHALL cover: two 4x4 frames back-to-back (0..15, then 100..115) -> 8 windows; second frame's first window {100,101,102,104,105,106,108,109,110}, with no first-frame data.
REQ-039 The bench SHALL cover: rstn=0 during row 2 of a 5x5 frame -> all outputs 0 next cycle; a fresh 5x5 frame yields 9 windows.
